// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle stage sequencer, PC and writeback register
// Optional halt-on-decode-error: define MULTICYCLE_CONTROLLER_HALT_ON_ERROR_EN.
module multicycle_controller #(
    parameter int               NUM_STAGES = 4,
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall_request,
    input  logic                          decoding_error,
    input  logic [XLEN-1:0]               new_pc,
    input  logic                          wb_rd_write_enabled,
    input  logic [4:0]                    wb_rd_index,
    input  logic [XLEN-1:0]               wb_rd_write_value,
    output logic                          stage_enable,
    output logic [$clog2(NUM_STAGES)-1:0] current_stage,
    output logic [XLEN-1:0]               program_counter,
    output logic                          rd_write_enabled,
    output logic [4:0]                    rd_index,
    output logic [XLEN-1:0]               rd_write_value,
    output logic                          halted,
    output logic [31:0]                   retired_count
);
    localparam int SW = $clog2(NUM_STAGES);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

    logic last_stage;
    logic halt_now;
    logic commit;

    assign stage_enable = !stall_request && !halted && !reset;
    assign last_stage   = (current_stage == LAST_STAGE);

`ifdef MULTICYCLE_CONTROLLER_HALT_ON_ERROR_EN
    logic halted_q;
    assign halted   = halted_q;
    assign halt_now = stage_enable && last_stage && decoding_error;

    always_ff @(posedge clk) begin
        if (reset)
            halted_q <= 1'b0;
        else if (halt_now)
            halted_q <= 1'b1;
    end

    logic unused_bits;
    assign unused_bits = ^new_pc[1:0];
`else
    assign halted   = 1'b0;
    assign halt_now = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{decoding_error, new_pc[1:0]};
`endif

    assign commit = stage_enable && last_stage && !halt_now;

    always_ff @(posedge clk) begin
        if (reset) begin
            current_stage    <= '0;
            program_counter  <= RESET_PC;
            rd_write_enabled <= 1'b0;
            rd_index         <= '0;
            rd_write_value   <= '0;
            retired_count    <= '0;
        end else begin
            // Write strobe is a single-cycle pulse, cleared on every non-commit edge.
            rd_write_enabled <= 1'b0;
            if (stage_enable && !halt_now)
                current_stage <= last_stage ? '0 : current_stage + 1'b1;
            if (commit) begin
                program_counter  <= {new_pc[XLEN-1:2], 2'b00};
                rd_write_enabled <= wb_rd_write_enabled && (wb_rd_index != 5'd0);
                rd_index         <= wb_rd_index;
                rd_write_value   <= wb_rd_write_value;
                retired_count    <= retired_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset3 = 1'b1;
    logic        stall_request = 1'b0;
    logic        decoding_error = 1'b0;
    logic [31:0] new_pc = '0;
    logic        wb_rd_write_enabled = 1'b0;
    logic [4:0]  wb_rd_index = '0;
    logic [31:0] wb_rd_write_value = '0;

    logic        stage_enable, rd_write_enabled, halted;
    logic [1:0]  current_stage;
    logic [31:0] program_counter, rd_write_value, retired_count;
    logic [4:0]  rd_index;

    logic        stage_enable3, rd_write_enabled3, halted3;
    logic [1:0]  current_stage3;
    logic [31:0] program_counter3, rd_write_value3, retired_count3;
    logic [4:0]  rd_index3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.NUM_STAGES(4), .XLEN(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .reset(reset), .stall_request(stall_request),
        .decoding_error(decoding_error), .new_pc(new_pc),
        .wb_rd_write_enabled(wb_rd_write_enabled), .wb_rd_index(wb_rd_index),
        .wb_rd_write_value(wb_rd_write_value), .stage_enable(stage_enable),
        .current_stage(current_stage), .program_counter(program_counter),
        .rd_write_enabled(rd_write_enabled), .rd_index(rd_index),
        .rd_write_value(rd_write_value), .halted(halted),
        .retired_count(retired_count)
    );

    multicycle_controller #(.NUM_STAGES(3), .XLEN(32), .RESET_PC(32'h200)) dut3 (
        .clk(clk), .reset(reset3), .stall_request(stall_request),
        .decoding_error(1'b0), .new_pc(new_pc),
        .wb_rd_write_enabled(wb_rd_write_enabled), .wb_rd_index(wb_rd_index),
        .wb_rd_write_value(wb_rd_write_value), .stage_enable(stage_enable3),
        .current_stage(current_stage3), .program_counter(program_counter3),
        .rd_write_enabled(rd_write_enabled3), .rd_index(rd_index3),
        .rd_write_value(rd_write_value3), .halted(halted3),
        .retired_count(retired_count3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        step(2);
        check("rst_stage", current_stage, 0);
        check("rst_pc", program_counter, 32'h100);
        check("rst_we", rd_write_enabled, 0);
        check("rst_idx", rd_index, 0);
        check("rst_val", rd_write_value, 0);
        check("rst_halted", halted, 0);
        check("rst_count", retired_count, 0);
        check("rst_en", stage_enable, 0);

        // Basic commit on the 4th edge after reset
        new_pc = 32'h10; wb_rd_write_enabled = 1'b1; wb_rd_index = 5'd5;
        wb_rd_write_value = 32'hDEADBEEF; reset = 1'b0;
        step(3);
        check("pre_stage", current_stage, 3);
        check("pre_we", rd_write_enabled, 0);
        check("pre_en", stage_enable, 1);
        step(1);
        check("c1_pc", program_counter, 32'h10);
        check("c1_we", rd_write_enabled, 1);
        check("c1_idx", rd_index, 5);
        check("c1_val", rd_write_value, 32'hDEADBEEF);
        check("c1_count", retired_count, 1);
        check("c1_stage", current_stage, 0);
        step(1);
        check("c1_pulse", rd_write_enabled, 0);

        // Stall in the last stage for three cycles
        step(2);
        check("st_stage0", current_stage, 3);
        new_pc = 32'h20; wb_rd_index = 5'd7; wb_rd_write_value = 32'h12345678;
        stall_request = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("st_stage", current_stage, 3);
            check("st_we", rd_write_enabled, 0);
            check("st_pc", program_counter, 32'h10);
            check("st_count", retired_count, 1);
            check("st_en", stage_enable, 0);
        end
        stall_request = 1'b0;
        step(1);
        check("c2_pc", program_counter, 32'h20);
        check("c2_we", rd_write_enabled, 1);
        check("c2_idx", rd_index, 7);
        check("c2_val", rd_write_value, 32'h12345678);
        check("c2_count", retired_count, 2);
        check("c2_stage", current_stage, 0);

        // x0 write suppressed, PC low bits cleared
        new_pc = 32'h13; wb_rd_index = 5'd0; wb_rd_write_value = 32'hCAFE;
        step(4);
        check("x0_pc", program_counter, 32'h10);
        check("x0_we", rd_write_enabled, 0);
        check("x0_idx", rd_index, 0);
        check("x0_count", retired_count, 3);

        // Decode error at the last stage
        step(3);
        check("de_stage", current_stage, 3);
        new_pc = 32'h40; wb_rd_index = 5'd9; decoding_error = 1'b1;
        step(1);
`ifdef MULTICYCLE_CONTROLLER_HALT_ON_ERROR_EN
        decoding_error = 1'b0;
        check("h_halted", halted, 1);
        check("h_pc", program_counter, 32'h10);
        check("h_count", retired_count, 3);
        check("h_we", rd_write_enabled, 0);
        check("h_en", stage_enable, 0);
        step(4);
        check("h_hold_pc", program_counter, 32'h10);
        check("h_hold_halted", halted, 1);
        reset = 1'b1;
        step(1);
        check("h_rst_pc", program_counter, 32'h100);
        check("h_rst_halted", halted, 0);
        check("h_rst_count", retired_count, 0);
        reset = 1'b0;
`else
        decoding_error = 1'b0;
        check("de_halted", halted, 0);
        check("de_pc", program_counter, 32'h40);
        check("de_count", retired_count, 4);
        check("de_we", rd_write_enabled, 1);
`endif

        // Three-stage instance: reset in the last stage, then counter wrap
        new_pc = 32'h50; wb_rd_write_enabled = 1'b1; wb_rd_index = 5'd9;
        wb_rd_write_value = 32'h55; reset3 = 1'b0;
        step(2);
        check("n3_stage", current_stage3, 2);
        reset3 = 1'b1;
        step(1);
        check("n3_rst_stage", current_stage3, 0);
        check("n3_rst_pc", program_counter3, 32'h200);
        check("n3_rst_count", retired_count3, 0);
        check("n3_rst_we", rd_write_enabled3, 0);
        reset3 = 1'b0;
        force dut3.retired_count = 32'hFFFF_FFFF;
        #1;
        release dut3.retired_count;
        step(3);
        check("wrap_count", retired_count3, 0);
        check("wrap_pc", program_counter3, 32'h50);
        check("wrap_we", rd_write_enabled3, 1);
        check("wrap_stage", current_stage3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
